bf_bus_ctrl: RTL and testbench

Bus controller sitting directly downstream of the BF interpreter core. It consumes the core's `bus_op`, `addr`, and `val_out` each cycle and services them against one shared external synchronous single-port memory, which holds both the program and the tape, and against a byte-stream I/O pair. It returns read data on `val_in` with the fixed one-cycle latency the core depends on. It raises `stall` when an I/O operation cannot complete; the core gates its `enable` with `stall`.

---
 rtl/bf_bus_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_bf_bus_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bf_bus_ctrl.sv
// Purpose: bus controller between the BF core and one shared program/tape memory plus a byte-stream I/O pair.
// Latency: memory and input reads return on val_in one cycle after the op; memory writes land on the same edge.
// Backpressure: stall is combinational, raised for ReadIo without in_valid or WriteIo into a full FIFO with out_ready low.
//
// Ports: clock/reset (async active-low); core side bus_op/addr/val_out/val_in/stall;
//        memory side mem_addr/mem_we/mem_re/mem_wdata/mem_rdata;
//        input stream in_data/in_valid/in_ready; output stream out_data/out_valid/out_ready.

// Output byte FIFO with a registered count.
// Push and pop take effect on the same edge, so a full FIFO can accept a push while it pops.
// The producer must not push when full unless the same cycle also pops.
module bf_out_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_vld,
    input  logic [DW-1:0] push_dat,
    output logic          full,
    output logic          pop_vld,
    output logic [DW-1:0] pop_dat,
    input  logic          pop_rdy
);
    localparam int PW = $clog2(DEPTH);

    logic [DW-1:0] store [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_pop;

    assign pop_vld = (count != '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop_vld & pop_rdy;
    // Empty FIFO presents zero rather than a stale head entry.
    assign pop_dat = pop_vld ? store[rd_ptr] : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) begin
                store[wr_ptr] <= push_dat;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_vld, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Top-level bus controller.
module bf_bus_ctrl #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            bus_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] val_out,
    output logic [DATA_WIDTH-1:0] val_in,
    output logic                  stall,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam logic [2:0] OP_READ_PROG = 3'd1;
    localparam logic [2:0] OP_READ_DATA = 3'd2;
    localparam logic [2:0] OP_WRITE_DATA = 3'd3;
    localparam logic [2:0] OP_READ_IO   = 3'd4;
    localparam logic [2:0] OP_WRITE_IO  = 3'd5;

    typedef enum logic {
        RD_IDLE,
        RD_MEM
    } rd_state_t;

    rd_state_t             state_q;
    rd_state_t             state_d;
    logic [DATA_WIDTH-1:0] last_rd;

    logic op_rd_prog;
    logic op_rd_data;
    logic op_wr_data;
    logic op_rd_io;
    logic op_wr_io;
    logic fifo_full;
    logic fifo_push;
    logic io_capture;

    // Decode is qualified with reset so every strobe and stall reads as
    // idle while reset is held, whatever the core drives.
    assign op_rd_prog = reset && (bus_op == OP_READ_PROG);
    assign op_rd_data = reset && (bus_op == OP_READ_DATA);
    assign op_wr_data = reset && (bus_op == OP_WRITE_DATA);
    assign op_rd_io   = reset && (bus_op == OP_READ_IO);
    assign op_wr_io   = reset && (bus_op == OP_WRITE_IO);

    // Full FIFO can still take a byte when the sink is popping this cycle.
    assign stall = (op_rd_io & ~in_valid)
                 | (op_wr_io & fifo_full & ~out_ready);

    assign mem_re     = op_rd_prog | op_rd_data;
    assign mem_we     = op_wr_data;
    assign mem_wdata  = op_wr_data ? val_out : '0;
    assign in_ready   = op_rd_io;
    assign io_capture = op_rd_io & in_valid;
    assign fifo_push  = op_wr_io & ~stall;

    // Program lives in the lower half, tape in the upper half.
    always_comb begin
        mem_addr = '0;
        if (op_rd_prog) begin
            mem_addr = {1'b0, addr};
        end else if (op_rd_data || op_wr_data) begin
            mem_addr = {1'b1, addr};
        end
    end

    // Read FSM: state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= RD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Read FSM: next state. Every memory read lands in RD_MEM, so
    // back-to-back reads simply stay there.
    always_comb begin
        state_d = RD_IDLE;
        if (mem_re) begin
            state_d = RD_MEM;
        end
    end

    // Read FSM: output. The memory returns data one cycle after mem_re,
    // so in RD_MEM it is forwarded straight through.
    always_comb begin
        val_in = last_rd;
        if (state_q == RD_MEM) begin
            val_in = mem_rdata;
        end
    end

    // last_rd holds whatever val_in last presented so that val_in stays
    // stable once the FSM drops back to idle. An input capture is the
    // newer value when both happen on one edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_rd <= '0;
        end else if (io_capture) begin
            last_rd <= in_data;
        end else if (state_q == RD_MEM) begin
            last_rd <= mem_rdata;
        end
    end

    bf_out_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clock    (clock),
        .reset    (reset),
        .push_vld (fifo_push),
        .push_dat (val_out),
        .full     (fifo_full),
        .pop_vld  (out_valid),
        .pop_dat  (out_data),
        .pop_rdy  (out_ready)
    );
endmodule

// File: tb/tb_bf_bus_ctrl.sv
// Purpose: self-checking bench for bf_bus_ctrl with a synchronous memory model and stream scoreboards.
// Latency: checks val_in one cycle after each read and out_data on each modelled pop.
// Backpressure: drives in_valid/out_ready patterns that exercise both stall causes.
module tb_bf_bus_ctrl;
    localparam int AW = 15;
    localparam int DW = 8;
    localparam int OD = 4;
    localparam int MSZ = 1 << (AW + 1);

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    bus_op = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] val_out = '0;
    logic [DW-1:0] val_in;
    logic          stall;
    logic [AW:0]   mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;

    always #5 clock = ~clock;

    bf_bus_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_DEPTH(OD)) dut (
        .clock(clock), .reset(reset), .bus_op(bus_op), .addr(addr),
        .val_out(val_out), .val_in(val_in), .stall(stall),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    // Initial memory image: pattern, with '+' at program address 5.
    function automatic logic [DW-1:0] init_pat(input logic [AW:0] a);
        logic [DW-1:0] p;
        p = a[DW-1:0] ^ 8'h5A;
        if (a == 16'h0005) p = 8'h2B;
        return p;
    endfunction

    // Environment memory: synchronous single port, read data one cycle after mem_re.
    logic [DW-1:0] env_mem [MSZ];
    logic          env_wr  [MSZ];
    always @(posedge clock) begin
        if (mem_we) begin
            env_mem[mem_addr] <= mem_wdata;
            env_wr[mem_addr]  <= 1'b1;
        end
        if (mem_re) begin
            mem_rdata <= env_wr[mem_addr] ? env_mem[mem_addr] : init_pat(mem_addr);
        end
    end

    // Reference memory, updated only from stimulus.
    logic [DW-1:0] ref_mem [MSZ];
    logic          ref_wr  [MSZ];

    typedef struct {
        logic [2:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] wdat;
        logic          in_vld;
        logic [DW-1:0] in_dat;
        logic          out_rdy;
        logic          exp_stall;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] rd_q[$];
    logic [DW-1:0] out_q[$];
    logic [DW-1:0] exp_val = '0;
    int            n_vec = 0;
    int            n_fail = 0;

    function automatic vec_t mk(input logic [2:0] op, input logic [AW-1:0] a,
                                input logic [DW-1:0] wdat, input logic in_vld,
                                input logic [DW-1:0] in_dat, input logic out_rdy,
                                input logic exp_stall);
        vec_t v;
        v.op = op; v.a = a; v.wdat = wdat; v.in_vld = in_vld;
        v.in_dat = in_dat; v.out_rdy = out_rdy; v.exp_stall = exp_stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW:0] a);
        return ref_wr[a] ? ref_mem[a] : init_pat(a);
    endfunction

    // One bus cycle: drive at negedge, check just after, update models for the coming edge.
    task automatic apply(input vec_t v);
        logic [AW:0] ea;
        logic        e_re;
        logic        e_we;
        @(negedge clock);
        if (rd_q.size() != 0) exp_val = rd_q.pop_front();
        bus_op = v.op; addr = v.a; val_out = v.wdat;
        in_valid = v.in_vld; in_data = v.in_dat; out_ready = v.out_rdy;
        #1;
        e_re = (v.op == 3'd1) || (v.op == 3'd2);
        e_we = (v.op == 3'd3);
        if (v.op == 3'd1)                      ea = {1'b0, v.a};
        else if (v.op == 3'd2 || v.op == 3'd3) ea = {1'b1, v.a};
        else                                   ea = '0;
        chk("val_in",    32'(val_in),    32'(exp_val));
        chk("stall",     32'(stall),     32'(v.exp_stall));
        chk("mem_re",    32'(mem_re),    32'(e_re));
        chk("mem_we",    32'(mem_we),    32'(e_we));
        chk("in_ready",  32'(in_ready),  32'(v.op == 3'd4));
        chk("mem_addr",  32'(mem_addr),  32'(ea));
        if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(v.wdat));
        chk("out_valid", 32'(out_valid), 32'(out_q.size() != 0));
        if (out_q.size() != 0 && v.out_rdy) chk("out_data", 32'(out_data), 32'(out_q.pop_front()));
        if (e_we) begin
            ref_mem[ea] = v.wdat;
            ref_wr[ea]  = 1'b1;
        end
        if (e_re) rd_q.push_back(ref_rd(ea));
        if (v.op == 3'd4 && v.in_vld) rd_q.push_back(v.in_dat);
        if (v.op == 3'd5 && !v.exp_stall) out_q.push_back(v.wdat);
    endtask

    initial begin
        for (int i = 0; i < MSZ; i++) begin
            ref_wr[i] = 1'b0;
        end

        // Reset state, including a ReadIo held on the bus during reset.
        bus_op = 3'd4; in_valid = 1'b0;
        #2;
        chk("rst_val_in",    32'(val_in),    32'h0);
        chk("rst_stall",     32'(stall),     32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data),  32'h0);
        chk("rst_mem_re",    32'(mem_re),    32'h0);
        chk("rst_mem_we",    32'(mem_we),    32'h0);
        chk("rst_mem_addr",  32'(mem_addr),  32'h0);
        bus_op = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        //              op    addr      wdat   iv  idat   ordy stall
        vecs.push_back(mk(3'd1, 15'h0005, 8'h00, 0, 8'h00, 0, 0)); // ReadProg '+'
        vecs.push_back(mk(3'd3, 15'h0003, 8'h41, 0, 8'h00, 0, 0)); // WriteData tape 3
        vecs.push_back(mk(3'd2, 15'h0003, 8'h00, 0, 8'h00, 0, 0)); // ReadData tape 3
        vecs.push_back(mk(3'd1, 15'h0003, 8'h00, 0, 8'h00, 0, 0)); // program 3 untouched
        vecs.push_back(mk(3'd4, 15'h0000, 8'h00, 0, 8'h7A, 0, 1)); // ReadIo, no data x3
        vecs.push_back(mk(3'd4, 15'h0000, 8'h00, 0, 8'h7A, 0, 1));
        vecs.push_back(mk(3'd4, 15'h0000, 8'h00, 0, 8'h7A, 0, 1));
        vecs.push_back(mk(3'd4, 15'h0000, 8'h00, 1, 8'h7A, 0, 0)); // handshake
        vecs.push_back(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 0, 0));
        for (int b = 1; b <= 4; b++)
            vecs.push_back(mk(3'd5, 15'h0000, 8'(b), 0, 8'h00, 0, 0));
        vecs.push_back(mk(3'd5, 15'h0000, 8'h05, 0, 8'h00, 0, 1)); // full, sink idle
        vecs.push_back(mk(3'd5, 15'h0000, 8'h05, 0, 8'h00, 1, 0)); // pop+push together
        for (int b = 0; b < 5; b++)
            vecs.push_back(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 1, 0)); // drain
        vecs.push_back(mk(3'd1, 15'h0000, 8'h00, 0, 8'h00, 0, 0)); // back-to-back reads
        vecs.push_back(mk(3'd1, 15'h0001, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(3'd6, 15'h0002, 8'h33, 1, 8'h44, 0, 0)); // illegal ops
        vecs.push_back(mk(3'd7, 15'h0004, 8'h55, 1, 8'h66, 0, 0));
        vecs.push_back(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 0, 0));
        vecs.push_back(mk(3'd2, 15'h0003, 8'h00, 0, 8'h00, 0, 0)); // read after idle, then ReadIo
        vecs.push_back(mk(3'd4, 15'h0000, 8'h00, 1, 8'hC3, 0, 0)); // capture in RdMem cycle
        vecs.push_back(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 0, 0));

        foreach (vecs[i]) apply(vecs[i]);

        // Fill the FIFO, stall a WriteIo, then assert reset mid-cycle.
        for (int b = 0; b < OD; b++)
            apply(mk(3'd5, 15'h0000, 8'hA0 + 8'(b), 0, 8'h00, 0, 0));
        apply(mk(3'd5, 15'h0000, 8'hAF, 0, 8'h00, 0, 1));
        chk("pre_rst_val_in", 32'(val_in != 8'h00), 32'h1);
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_stall",     32'(stall),     32'h0);
        chk("mid_rst_val_in",    32'(val_in),    32'h0);
        chk("mid_rst_out_data",  32'(out_data),  32'h0);
        bus_op = '0; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clock);
        rd_q.delete();
        out_q.delete();
        exp_val = '0;
        reset = 1'b1;

        // First ops after reset behave as from idle with an empty FIFO.
        apply(mk(3'd1, 15'h0005, 8'h00, 0, 8'h00, 0, 0));
        apply(mk(3'd5, 15'h0000, 8'hE1, 0, 8'h00, 0, 0));
        apply(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 1, 0));
        apply(mk(3'd0, 15'h0000, 8'h00, 0, 8'h00, 1, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
